// File: rtl/mnist_loader_seq_pkg.sv
// Shared state encoding and default geometry for the MNIST loader sequencer.
package mnist_loader_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD_W  = 3'd1;
  localparam state_t ST_LOAD_X  = 3'd2;
  localparam state_t ST_SETTLE  = 3'd3;
  localparam state_t ST_COMPUTE = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam int DEF_W_ADDR_LEN = 20;
  localparam int DEF_X_ADDR_LEN = 10;
  localparam int DEF_W_SEL_LEN  = 2;
  localparam int DEF_X_SEL_LEN  = 2;
  localparam int DEF_W_DEPTH    = 7840;
  localparam int DEF_W_BANKS    = 4;
  localparam int DEF_X_DEPTH    = 784;
  localparam int DEF_X_BANKS    = 1;
  localparam int DEF_CNT_LEN    = 16;

  function automatic logic is_loading(input state_t st);
    return (st == ST_LOAD_W) || (st == ST_LOAD_X);
  endfunction

endpackage

// File: rtl/mnist_loader_seq_if.sv
// Host handshake, compute hand-off and off-chip memory port of the loader.
interface mnist_loader_seq_if
  import mnist_loader_seq_pkg::*;
#(
  parameter int W_ADDR_LEN = DEF_W_ADDR_LEN,
  parameter int X_ADDR_LEN = DEF_X_ADDR_LEN,
  parameter int W_SEL_LEN  = DEF_W_SEL_LEN,
  parameter int X_SEL_LEN  = DEF_X_SEL_LEN,
  parameter int CNT_LEN    = DEF_CNT_LEN
) ();

  logic                  start;
  logic                  load_w;
  logic                  abort;
  logic                  in_valid;
  logic                  in_bit;
  logic                  in_ready;
  logic                  load_compute_ctrl;
  logic                  en_compute;
  logic                  compute_finish;
  logic                  w_wq_oc;
  logic                  x_wq_oc;
  logic [W_ADDR_LEN-1:0] w_addr_oc;
  logic [X_ADDR_LEN-1:0] x_addr_oc;
  logic [W_SEL_LEN-1:0]  w_sel_oc;
  logic [X_SEL_LEN-1:0]  x_sel_oc;
  logic                  wx_write_oc;
  logic                  busy;
  logic                  done;
  logic [CNT_LEN-1:0]    img_count;

  modport master (
    output start, load_w, abort, in_valid, in_bit, compute_finish,
    input  in_ready, load_compute_ctrl, en_compute, w_wq_oc, x_wq_oc,
    input  w_addr_oc, x_addr_oc, w_sel_oc, x_sel_oc, wx_write_oc,
    input  busy, done, img_count
  );

  modport slave (
    input  start, load_w, abort, in_valid, in_bit, compute_finish,
    output in_ready, load_compute_ctrl, en_compute, w_wq_oc, x_wq_oc,
    output w_addr_oc, x_addr_oc, w_sel_oc, x_sel_oc, wx_write_oc,
    output busy, done, img_count
  );

endinterface

// File: rtl/mnist_loader_seq_bank_addr_counter.sv
// Address (inner) / bank select (outer) counter for one memory; last_o flags
// that the current position is the final bit of the final bank.
module bank_addr_counter #(
  parameter int ADDR_LEN = 10,
  parameter int SEL_LEN  = 2,
  parameter int DEPTH    = 784,
  parameter int BANKS    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [ADDR_LEN-1:0] addr_o,
  output logic [SEL_LEN-1:0]  sel_o,
  output logic                last_o
);

  localparam logic [ADDR_LEN-1:0] ADDR_MAX = ADDR_LEN'(DEPTH - 1);
  localparam logic [SEL_LEN-1:0]  SEL_MAX  = SEL_LEN'(BANKS - 1);

  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [SEL_LEN-1:0]  sel_q, sel_d;
  logic                addr_wrap;

  assign addr_wrap = (addr_q == ADDR_MAX);
  assign last_o    = addr_wrap && (sel_q == SEL_MAX);
  assign addr_o    = addr_q;
  assign sel_o     = sel_q;

  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    if (clr_i) begin
      addr_d = '0;
      sel_d  = '0;
    end else if (inc_i) begin
      if (addr_wrap) begin
        addr_d = '0;
        // Wrap the bank back to 0 after the final bit so a fresh pass is clean.
        sel_d  = last_o ? '0 : sel_q + SEL_LEN'(1);
      end else begin
        addr_d = addr_q + ADDR_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      sel_q  <= '0;
    end else begin
      addr_q <= addr_d;
      sel_q  <= sel_d;
    end
  end

endmodule

// File: rtl/mnist_loader_seq.sv
// Streams host bits into weight/input memories, hands the port to
// compute_module, waits for compute_finish and counts completed images.
module mnist_loader_seq
  import mnist_loader_seq_pkg::*;
#(
  parameter int W_ADDR_LEN = DEF_W_ADDR_LEN,
  parameter int X_ADDR_LEN = DEF_X_ADDR_LEN,
  parameter int W_SEL_LEN  = DEF_W_SEL_LEN,
  parameter int X_SEL_LEN  = DEF_X_SEL_LEN,
  parameter int W_DEPTH    = DEF_W_DEPTH,
  parameter int W_BANKS    = DEF_W_BANKS,
  parameter int X_DEPTH    = DEF_X_DEPTH,
  parameter int X_BANKS    = DEF_X_BANKS,
  parameter int CNT_LEN    = DEF_CNT_LEN
) (
  input logic               clk,
  input logic               rst_n,
  mnist_loader_seq_if.slave bus
);

  // state      | meaning
  // IDLE       | waiting for start, loader owns memory port
  // LOAD_W     | accepting weight bits, writing weight banks
  // LOAD_X     | accepting pixel bits, writing input banks
  // SETTLE     | final registered write lands before hand-off
  // COMPUTE    | compute_module owns memories, en_compute held
  // DONE       | one-cycle done pulse, image counter advances

  state_t state_q, state_d;

  logic                  in_ready;
  logic                  accept;
  logic                  w_inc, x_inc, w_clr, x_clr;
  logic                  w_last, x_last;
  logic [W_ADDR_LEN-1:0] w_cnt_addr;
  logic [X_ADDR_LEN-1:0] x_cnt_addr;
  logic [W_SEL_LEN-1:0]  w_cnt_sel;
  logic [X_SEL_LEN-1:0]  x_cnt_sel;

  logic                  w_wq_q, x_wq_q, wx_write_q;
  logic [W_ADDR_LEN-1:0] w_addr_q;
  logic [X_ADDR_LEN-1:0] x_addr_q;
  logic [W_SEL_LEN-1:0]  w_sel_q;
  logic [X_SEL_LEN-1:0]  x_sel_q;
  logic [CNT_LEN-1:0]    img_cnt_q;

  assign in_ready = is_loading(state_q);
  // An abort in the same cycle as a bit suppresses both the write and the count.
  assign accept   = bus.in_valid && in_ready && !bus.abort;
  assign w_inc    = accept && (state_q == ST_LOAD_W);
  assign x_inc    = accept && (state_q == ST_LOAD_X);
  assign w_clr    = (state_q == ST_IDLE);
  assign x_clr    = (state_q == ST_IDLE) || (w_inc && w_last);

  bank_addr_counter #(
    .ADDR_LEN (W_ADDR_LEN),
    .SEL_LEN  (W_SEL_LEN),
    .DEPTH    (W_DEPTH),
    .BANKS    (W_BANKS)
  ) u_w_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (w_clr),
    .inc_i  (w_inc),
    .addr_o (w_cnt_addr),
    .sel_o  (w_cnt_sel),
    .last_o (w_last)
  );

  bank_addr_counter #(
    .ADDR_LEN (X_ADDR_LEN),
    .SEL_LEN  (X_SEL_LEN),
    .DEPTH    (X_DEPTH),
    .BANKS    (X_BANKS)
  ) u_x_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (x_clr),
    .inc_i  (x_inc),
    .addr_o (x_cnt_addr),
    .sel_o  (x_cnt_sel),
    .last_o (x_last)
  );

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (bus.start) state_d = bus.load_w ? ST_LOAD_W : ST_LOAD_X;
        ST_LOAD_W:  if (w_inc && w_last) state_d = ST_LOAD_X;
        ST_LOAD_X:  if (x_inc && x_last) state_d = ST_SETTLE;
        ST_SETTLE:  state_d = ST_COMPUTE;
        ST_COMPUTE: if (bus.compute_finish) state_d = ST_DONE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      w_wq_q     <= 1'b0;
      x_wq_q     <= 1'b0;
      wx_write_q <= 1'b0;
      w_addr_q   <= '0;
      x_addr_q   <= '0;
      w_sel_q    <= '0;
      x_sel_q    <= '0;
      img_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      w_wq_q  <= w_inc;
      x_wq_q  <= x_inc;
      if (accept) wx_write_q <= bus.in_bit;
      if (w_inc) begin
        w_addr_q <= w_cnt_addr;
        w_sel_q  <= w_cnt_sel;
      end
      if (x_inc) begin
        x_addr_q <= x_cnt_addr;
        x_sel_q  <= x_cnt_sel;
      end
      if ((state_q == ST_DONE) && !bus.abort) img_cnt_q <= img_cnt_q + CNT_LEN'(1);
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.load_compute_ctrl = (state_q != ST_COMPUTE);
  assign bus.en_compute        = (state_q == ST_COMPUTE);
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.done              = (state_q == ST_DONE);
  assign bus.w_wq_oc           = w_wq_q;
  assign bus.x_wq_oc           = x_wq_q;
  assign bus.wx_write_oc       = wx_write_q;
  assign bus.w_addr_oc         = w_addr_q;
  assign bus.x_addr_oc         = x_addr_q;
  assign bus.w_sel_oc          = w_sel_q;
  assign bus.x_sel_oc          = x_sel_q;
  assign bus.img_count         = img_cnt_q;

endmodule

// File: tb/tb_mnist_loader_seq.sv
// Scoreboard bench for mnist_loader_seq: expected writes are queued as bits are
// offered and a negedge monitor matches every memory write against the queue.
module tb_mnist_loader_seq;

  localparam int WD = 4;
  localparam int WB = 2;
  localparam int XD = 3;
  localparam int XB = 1;
  localparam int WT = WD * WB;
  localparam int XT = XD * XB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mnist_loader_seq_if bus ();

  mnist_loader_seq #(
    .W_DEPTH (WD),
    .W_BANKS (WB),
    .X_DEPTH (XD),
    .X_BANKS (XB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit is_w;
    int sel;
    int addr;
    bit b;
  } wr_t;

  wr_t exp_q[$];
  bit  stim_bits[$];
  int  total = 0;
  int  bad = 0;
  int  done_seen = 0;
  int  model_count = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference position of stream bit k within a job: pure arithmetic on the index.
  function automatic wr_t model_write(input bit lw, input int k, input bit b);
    wr_t w;
    int  xi;
    w.b = b;
    if (lw && k < WT) begin
      w.is_w = 1'b1;
      w.sel  = k / WD;
      w.addr = k % WD;
    end else begin
      xi     = lw ? k - WT : k;
      w.is_w = 1'b0;
      w.sel  = xi / XD;
      w.addr = xi % XD;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    int  g_sel, g_addr;
    if (rst_n) begin
      if (bus.done) done_seen++;
      if (bus.w_wq_oc && bus.x_wq_oc) begin
        total++;
        bad++;
        $display("FAIL dual_wq: got w_wq=1 x_wq=1 required at most one");
      end else if (bus.w_wq_oc || bus.x_wq_oc) begin
        total++;
        g_sel  = bus.w_wq_oc ? int'(bus.w_sel_oc)  : int'(bus.x_sel_oc);
        g_addr = bus.w_wq_oc ? int'(bus.w_addr_oc) : int'(bus.x_addr_oc);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got w=%0d sel=%0d addr=%0d bit=%0d required no write",
                   bus.w_wq_oc, g_sel, g_addr, bus.wx_write_oc);
        end else begin
          e = exp_q.pop_front();
          if (e.is_w != bus.w_wq_oc || e.sel != g_sel || e.addr != g_addr || e.b != bus.wx_write_oc) begin
            bad++;
            $display("FAIL write_check: got w=%0d sel=%0d addr=%0d bit=%0d required w=%0d sel=%0d addr=%0d bit=%0d",
                     bus.w_wq_oc, g_sel, g_addr, bus.wx_write_oc, e.is_w, e.sel, e.addr, e.b);
          end
        end
      end
    end
  end

  task automatic run_job(input bit lw, input bit gaps, input int ncomp, input int abort_at,
                         input bit start_in_comp, input bit abort_in_comp);
    int n, idx, cyc;
    bit v, b;
    n = (lw ? WT : 0) + XT;
    while (stim_bits.size() < n) stim_bits.push_back(1'($urandom));
    bus.start  = 1'b1;
    bus.load_w = lw;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.load_w = 1'($urandom);
    chk("busy_after_start", bus.busy, 1);
    idx = 0;
    cyc = 0;
    while (idx < n) begin
      if (cyc > 200) begin
        chk("load_timeout", idx, n);
        break;
      end
      cyc++;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      b = stim_bits[idx];
      bus.in_valid = v;
      bus.in_bit   = v ? b : 1'($urandom);
      if (v && idx == abort_at) bus.abort = 1'b1;
      else if (v) exp_q.push_back(model_write(lw, idx, b));
      chk("in_ready_load", bus.in_ready, 1);
      @(posedge clk); #1;
      if (v && idx == abort_at) begin
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_en", bus.en_compute, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_lcc", bus.load_compute_ctrl, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pending", exp_q.size(), 0);
        chk("abort_img_count", bus.img_count, model_count);
        chk("abort_done_count", done_seen, model_count);
        stim_bits.delete();
        return;
      end
      if (v) idx++;
    end
    bus.in_valid = 1'b0;
    chk("settle_in_ready", bus.in_ready, 0);
    chk("settle_lcc", bus.load_compute_ctrl, 1);
    chk("settle_en", bus.en_compute, 0);
    chk("settle_x_wq", bus.x_wq_oc, 1);
    @(posedge clk); #1;
    for (int c = 0; c < ncomp; c++) begin
      chk("comp_en", bus.en_compute, 1);
      chk("comp_lcc", bus.load_compute_ctrl, 0);
      chk("comp_wq", bus.w_wq_oc | bus.x_wq_oc, 0);
      chk("comp_done", bus.done, 0);
      bus.start = start_in_comp && (c == 0);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("comp_en_final", bus.en_compute, 1);
    bus.compute_finish = 1'b1;
    bus.abort          = abort_in_comp;
    @(posedge clk); #1;
    bus.compute_finish = 1'b0;
    bus.abort          = 1'b0;
    if (abort_in_comp) begin
      chk("comp_abort_busy", bus.busy, 0);
      chk("comp_abort_done", bus.done, 0);
      chk("comp_abort_en", bus.en_compute, 0);
    end else begin
      chk("done_pulse", bus.done, 1);
      chk("done_en", bus.en_compute, 0);
      chk("done_lcc", bus.load_compute_ctrl, 1);
      model_count++;
      @(posedge clk); #1;
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
    end
    chk("img_count", bus.img_count, model_count % 65536);
    chk("done_count", done_seen, model_count);
    chk("writes_pending", exp_q.size(), 0);
    stim_bits.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.load_w = 0; bus.abort = 0;
    bus.in_valid = 0; bus.in_bit = 0; bus.compute_finish = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_lcc", bus.load_compute_ctrl, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);

    // Reset asserted in the middle of a weight load.
    bus.start = 1'b1; bus.load_w = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'($urandom);
      exp_q.push_back(model_write(1'b1, i, bus.in_bit));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_w_addr", bus.w_addr_oc, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_lcc", bus.load_compute_ctrl, 1);
    chk("rst_mid_wq", bus.w_wq_oc | bus.x_wq_oc, 0);
    chk("rst_mid_en", bus.en_compute, 0);
    chk("rst_mid_w_addr", bus.w_addr_oc, 0);
    chk("rst_mid_x_addr", bus.x_addr_oc, 0);
    chk("rst_mid_img", bus.img_count, 0);
    chk("rst_mid_busy", bus.busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed 11-bit stream, 20 cycles of compute.
    stim_bits = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0};
    run_job(1'b1, 1'b0, 20, -1, 1'b0, 1'b0);

    // Pixels only with valid gaps and a stray start during compute.
    run_job(1'b0, 1'b1, 3, -1, 1'b1, 1'b0);

    // compute_finish in IDLE is ignored.
    bus.compute_finish = 1'b1;
    @(posedge clk); #1;
    bus.compute_finish = 1'b0;
    chk("cf_idle_busy", bus.busy, 0);
    chk("cf_idle_done", bus.done, 0);
    @(posedge clk); #1;
    chk("cf_idle_img", bus.img_count, model_count);
    chk("cf_idle_done_count", done_seen, model_count);

    // Abort on the 6th accepted bit, then a full job restarting from 0/0.
    run_job(1'b1, 1'b1, 0, 5, 1'b0, 1'b0);
    run_job(1'b1, 1'b0, 1, -1, 1'b0, 1'b0);

    // Abort racing compute_finish in COMPUTE.
    run_job(1'b0, 1'b0, 2, -1, 1'b0, 1'b1);

    // Simultaneous start and abort in IDLE.
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_idle", bus.busy, 0);

    for (int j = 0; j < 4; j++) begin
      run_job(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 5), -1, 1'b0, 1'b0);
      @(posedge clk); #1;
    end

    rst_n = 1'b0;
    #1;
    chk("final_rst_img", bus.img_count, 0);
    chk("final_rst_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
